// File: rtl/sram_map_pkg.sv
// Shared address map and helpers for the data SRAM responder:
// MMIO window selector, register offsets, read-select encoding and byte merge.
package sram_map_pkg;

    localparam logic [15:0] MMIO_HI   = 16'hBFAF;
    localparam logic [15:0] LED_OFS   = 16'hF000;
    localparam logic [15:0] TIMER_OFS = 16'hE000;

    // Source of data_sram_rdata for the cycle after a read.
    // SEL_NONE (the reset value) forces the output to zero until the first read.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_MMIO = 2'd2
    } rd_sel_e;

    // Replace the byte lanes of old_word whose enable bit is set with new_word.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  wen
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/bram_be_sp.sv
// Single-port synchronous RAM with four byte-lane write enables and a
// registered read port. No reset, so synthesis can map it onto block RAM.
// The read register only loads on a read; it holds across writes and idles.
module bram_be_sp #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_r [0:(2**ADDR_WIDTH)-1];
    logic [31:0] rdata_r;

    // Byte-lane write or registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) begin
                        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the core's data SRAM port. Returns read data one
// cycle after the request from either the byte-writable RAM or a small MMIO
// window (LED register, free-running timer).
module data_sram_responder #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [15:0] MMIO_HI    = sram_map_pkg::MMIO_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led
);

    import sram_map_pkg::*;

    logic        is_mmio_s;
    logic [15:0] ofs_s;
    logic        rd_s;
    logic        wr_s;
    logic        ram_en_s;
    logic [3:0]  ram_we_s;
    logic        led_wr_s;
    logic        timer_wr_s;
    logic [31:0] mmio_rdata_s;
    logic [31:0] led_merged_s;
    logic [31:0] timer_merged_s;
    logic [31:0] ram_q_s;
    logic [31:0] rdata_mux_s;

    logic [15:0] led_r;
    logic [31:0] timer_r;
    logic [31:0] mmio_rd_r;
    rd_sel_e     sel_r;

    logic        unused_s;

    // Address decode and request classification.
    always_comb begin
        is_mmio_s  = (data_sram_addr[31:16] == MMIO_HI);
        ofs_s      = data_sram_addr[15:0];
        rd_s       = data_sram_en && (data_sram_wen == 4'b0000);
        wr_s       = data_sram_en && (data_sram_wen != 4'b0000);
        // Requests seen while reset is asserted never reach the RAM.
        ram_en_s   = data_sram_en && !is_mmio_s && rst;
        ram_we_s   = data_sram_wen;
        led_wr_s   = wr_s && is_mmio_s && (ofs_s == LED_OFS);
        timer_wr_s = wr_s && is_mmio_s && (ofs_s == TIMER_OFS);
    end

    // MMIO read value for the current request (timer is its pre-edge value).
    always_comb begin
        mmio_rdata_s = 32'h0000_0000;
        case (ofs_s)
            LED_OFS:   mmio_rdata_s = {16'h0000, led_r};
            TIMER_OFS: mmio_rdata_s = timer_r;
            default:   mmio_rdata_s = 32'h0000_0000;
        endcase
    end

    assign led_merged_s   = byte_merge({16'h0000, led_r}, data_sram_wdata, data_sram_wen);
    assign timer_merged_s = byte_merge(timer_r, data_sram_wdata, data_sram_wen);

    bram_be_sp #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (data_sram_addr[ADDR_WIDTH+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_q_s)
    );

    // Free-running timer; a write loads the merged value instead of counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_r <= 32'h0000_0000;
        end else if (timer_wr_s) begin
            timer_r <= timer_merged_s;
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // LED register, byte-lane writable over its low 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_r <= 16'h0000;
        end else if (led_wr_s) begin
            led_r <= led_merged_s[15:0];
        end
    end

    // Read-source select and latched MMIO read data; updated only on reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_r     <= SEL_NONE;
            mmio_rd_r <= 32'h0000_0000;
        end else if (rd_s) begin
            if (is_mmio_s) begin
                sel_r     <= SEL_MMIO;
                mmio_rd_r <= mmio_rdata_s;
            end else begin
                sel_r     <= SEL_RAM;
            end
        end
    end

    // Steer read data from flops only; SEL_NONE gives zero straight out of reset.
    always_comb begin
        rdata_mux_s = 32'h0000_0000;
        case (sel_r)
            SEL_RAM:  rdata_mux_s = ram_q_s;
            SEL_MMIO: rdata_mux_s = mmio_rd_r;
            default:  rdata_mux_s = 32'h0000_0000;
        endcase
    end

    assign data_sram_rdata = rdata_mux_s;
    assign led             = led_r;

    // Word-aligned port: byte offset bits and the unused merge lanes are dropped.
    assign unused_s = ^{data_sram_addr[1:0], led_merged_s[31:16]};

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Memory-side responder for the core's data SRAM port: it accepts the `data_sram_*` requests the pipeline issues from EX and returns read data exactly one cycle later, so the value is available to MEM. It holds a byte-writable on-chip RAM, plus a small MMIO window with an LED register and a free-running timer. It sits in the SoC top between the core and the board pins.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: word-address bits of the RAM (2^14 words = 64 KiB).
- `MMIO_HI`, 16'hBFAF: value of `addr[31:16]` that selects the MMIO window.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_wen`  in  4  byte write enables; lane i covers bits [8i+7:8i]; 4'b0000 = read.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  write data, lane-aligned.
- `data_sram_rdata`  out  32  read data, registered.
- `led`  out  16  LED register value, registered.

## Operation
- Decode: MMIO when `addr[31:16]==MMIO_HI`, otherwise RAM.
  - RAM word index is `addr[ADDR_WIDTH+1:2]`.
  - Higher bits are ignored, so addresses alias.
- MMIO offsets, from `addr[15:0]`:
  - 16'hF000 LED: bits [15:0], read/write; upper bits read 0.
  - 16'hE000 TIMER: 32-bit, read/write.
  - Any other offset reads 0 and ignores writes.
- Read (`en=1`, `wen=0`): `data_sram_rdata` is loaded with the addressed word at the edge.
- Write (`en=1`, `wen!=0`):
  - Only the enabled lanes of the target are updated; disabled lanes keep their old bytes.
  - `data_sram_rdata` holds its previous value.
- Idle (`en=0`): no state change except TIMER; `data_sram_rdata` holds.
- TIMER:
  - Increments by 1 every cycle, wrapping 32'hFFFF_FFFF→0.
  - On a write to TIMER the merged value is loaded and the increment for that cycle is skipped.
  - A TIMER read returns the pre-edge value, i.e. the value during the request cycle.
- Reset (`rst=0`, asynchronous):
  - `data_sram_rdata`=0, `led`=0, TIMER=0.
  - RAM contents are not cleared and stay undefined until written.
  - Any request in flight when reset asserts is discarded.

## Timing
- Read latency: exactly 1 cycle; data is valid from the edge after the request cycle until the next read edge.
- Back-to-back requests are accepted every cycle; there is no stall or backpressure.
- Write then read of the same word in the next cycle: the read returns the newly written bytes.
- Single port, so a read and a write in the same cycle cannot occur.
- Reset deassertion: the first request is accepted on the first rising edge with `rst=1`; TIMER reads 1 one cycle after that edge.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Structure
- Shared package `sram_map_pkg`:
  - `MMIO_HI`
  - offsets `LED_OFS`=16'hF000 and `TIMER_OFS`=16'hE000
  - a byte-merge function (old, new, wen) → word.
- Sub-module `bram_be_sp`:
  - Single-port synchronous RAM, parameterised depth, 4 byte enables, registered output, no reset.
  - Inferable as block RAM.
- Top level:
  - Address decode and MMIO registers.
  - A one-cycle registered select (RAM vs MMIO, with the MMIO read value latched) that steers `data_sram_rdata`.

## Test plan
- Reset then idle:
  - `rst`=0 for 3 cycles, then 1 → `data_sram_rdata`=0 and `led`=0.
  - A TIMER read issued 4 cycles after release returns 4.
- Full write/read:
  - Write 32'hDEADBEEF, `wen`=4'hF, to 32'h0000_0100; read 32'h0000_0100 next cycle → rdata=32'hDEADBEEF one cycle later.
- Byte lanes:
  - After the above, write 32'h0000_5500 with `wen`=4'b0010 → a read returns 32'hDEAD55EF.
  - Write with `wen`=4'b1000, wdata 32'h1200_0000 → a read returns 32'h12AD55EF.
- Aliasing and hold:
  - With `ADDR_WIDTH`=14, a read of 32'h0001_0100 returns 32'h12AD55EF.
  - Drop `en` for 5 cycles → rdata holds 32'h12AD55EF throughout.
- MMIO:
  - Write 32'hFFFF_A5A5 to 32'hBFAF_F000 → `led`=16'hA5A5 next cycle; reading it back returns 32'h0000_A5A5.
  - A read of 32'hBFAF_1234 returns 0.
- Timer load and wrap:
  - Write 32'hFFFF_FFFE to TIMER, then read on consecutive cycles → 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0.
  - Assert `rst` mid-sequence → rdata drops to 0 immediately, without waiting for a clock edge.
